// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache frame layout, geometry, FSM states and
// the saturating increment used by the statistics counters.
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-frame instruction cache: zero-latency hits,
// a single outstanding miss fill, and saturating hit/miss statistics.
module icache_dm
  import cpu_types_pkg::*;
#(
  // SETS must equal ICACHE_SETS: the frame type's tag field is sized from it.
  parameter int          SETS    = ICACHE_SETS,
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state, state_n;
  icache_frame_t frames [SETS];
  icache_frame_t rd_frame;

  logic [29:0]      fill_addr;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             lookup_hit;
  logic             start_fill;
  logic             fill_done;
  logic [31:0]      hit_q;
  logic [31:0]      miss_q;

  assign req_idx    = imemaddr[IDX_W+1:2];
  assign req_tag    = imemaddr[31:IDX_W+2];
  assign rd_frame   = frames[req_idx];
  assign lookup_hit = imemREN && rd_frame.valid && (rd_frame.tag == req_tag);

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    ihit       = 1'b0;
    imemload   = 32'h0;
    iREN       = 1'b0;
    iaddr      = 32'h0;
    start_fill = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (lookup_hit) begin
          ihit     = 1'b1;
          imemload = rd_frame.data;
        end else if (imemREN) begin
          start_fill = 1'b1;
          state_n    = FETCH;
        end
      end
      FETCH: begin
        // The fill runs to completion on fill_addr regardless of what the
        // datapath presents meanwhile; no forwarding on the completion cycle.
        iREN  = 1'b1;
        iaddr = {fill_addr, 2'b00};
        if (!iwait) begin
          fill_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      fill_addr <= 30'h0;
      hit_q     <= 32'h0;
      miss_q    <= 32'h0;
    end else begin
      state <= state_n;
      if (start_fill) begin
        fill_addr <= imemaddr[31:2];
        miss_q    <= sat_inc(miss_q);
      end
      if (ihit) hit_q <= sat_inc(hit_q);
    end
  end

  // NOTE: only the valid bits are reset; tag and data are qualified by valid,
  // so resetting the whole array would just add reset fan-out to the storage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SETS; i++) frames[i].valid <= 1'b0;
    end else if (fill_done) begin
      frames[fill_addr[IDX_W-1:0]].valid <= 1'b1;
      frames[fill_addr[IDX_W-1:0]].tag   <= fill_addr[29:IDX_W];
      frames[fill_addr[IDX_W-1:0]].data  <= iload;
    end
  end

  // Byte-offset bits and PC_INIT carry no logic.
  logic unused_ok;
  assign unused_ok = ^{PC_INIT, imemaddr[1:0]};

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a per-cycle vector table covering fills,
// hits, conflicts, fetch-time address changes and mid-fill reset, plus a
// hand-written hit-counter saturation sequence.
module tb_icache_dm;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  icache_dm dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        iwait;
    logic [31:0] iload;
    logic        chk;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_iren;
    logic [31:0] e_iaddr;
    logic [31:0] e_hits;
    logic [31:0] e_misses;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic ren, input logic [31:0] addr,
                              input logic iw, input logic [31:0] il, input logic chk,
                              input logic e_hit, input logic [31:0] e_load,
                              input logic e_iren, input logic [31:0] e_iaddr,
                              input logic [31:0] e_hits, input logic [31:0] e_misses);
    vec_t v;
    v.rst = rst; v.ren = ren; v.addr = addr; v.iwait = iw; v.iload = il; v.chk = chk;
    v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
    v.e_hits = e_hits; v.e_misses = e_misses;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;

    //              rst ren addr          iw  iload          chk hit load           iren iaddr         hits           misses
    // Cold miss on 0x0 with two wait cycles, then hits
    vecs[0]  = mk(1, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,        0, 32'h0,  32'd0, 32'd0);
    vecs[1]  = mk(0, 1, 32'h0,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd0, 32'd0);
    vecs[2]  = mk(0, 1, 32'h0,        1, 32'h0,        1, 0, 32'h0,        1, 32'h0,  32'd0, 32'd1);
    vecs[3]  = mk(0, 1, 32'h0,        1, 32'h0,        1, 0, 32'h0,        1, 32'h0,  32'd0, 32'd1);
    vecs[4]  = mk(0, 1, 32'h0,        0, 32'h2001_0004, 1, 0, 32'h0,       1, 32'h0,  32'd0, 32'd1);
    vecs[5]  = mk(0, 1, 32'h0,        1, 32'h0,        1, 1, 32'h2001_0004, 0, 32'h0, 32'd0, 32'd1);
    vecs[6]  = mk(0, 1, 32'h0,        1, 32'h0,        1, 1, 32'h2001_0004, 0, 32'h0, 32'd1, 32'd1);
    vecs[7]  = mk(0, 0, 32'h0,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd2, 32'd1);
    // Conflict on index 0: 0x40 evicts 0x0, then 0x0 evicts 0x40
    vecs[8]  = mk(0, 1, 32'h40,       1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd2, 32'd1);
    vecs[9]  = mk(0, 1, 32'h40,       0, 32'hAAAA_0040, 1, 0, 32'h0,       1, 32'h40, 32'd2, 32'd2);
    vecs[10] = mk(0, 1, 32'h40,       1, 32'h0,        1, 1, 32'hAAAA_0040, 0, 32'h0, 32'd2, 32'd2);
    vecs[11] = mk(0, 1, 32'h0,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd3, 32'd2);
    vecs[12] = mk(0, 1, 32'h0,        0, 32'h2001_0004, 1, 0, 32'h0,       1, 32'h0,  32'd3, 32'd3);
    vecs[13] = mk(0, 1, 32'h0,        1, 32'h0,        1, 1, 32'h2001_0004, 0, 32'h0, 32'd3, 32'd3);
    // Fill of 0x8 while the datapath moves to 0xC / drops imemREN
    vecs[14] = mk(0, 1, 32'h8,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd4, 32'd3);
    vecs[15] = mk(0, 0, 32'hC,        1, 32'h0,        1, 0, 32'h0,        1, 32'h8,  32'd4, 32'd4);
    vecs[16] = mk(0, 1, 32'hC,        1, 32'h0,        1, 0, 32'h0,        1, 32'h8,  32'd4, 32'd4);
    vecs[17] = mk(0, 1, 32'hC,        0, 32'h1111_0008, 1, 0, 32'h0,       1, 32'h8,  32'd4, 32'd4);
    vecs[18] = mk(0, 1, 32'hC,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd4, 32'd4);
    vecs[19] = mk(0, 0, 32'hC,        0, 32'h2222_000C, 1, 0, 32'h0,       1, 32'hC,  32'd4, 32'd5);
    vecs[20] = mk(0, 1, 32'h8,        1, 32'h0,        1, 1, 32'h1111_0008, 0, 32'h0, 32'd4, 32'd5);
    // Reset in the completion cycle of a fill of 0x10
    vecs[21] = mk(0, 1, 32'h10,       1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd5, 32'd5);
    vecs[22] = mk(1, 1, 32'h10,       0, 32'h3333_0010, 1, 0, 32'h0,       1, 32'h10, 32'd5, 32'd6);
    vecs[23] = mk(0, 0, 32'h10,       1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd0, 32'd0);
    vecs[24] = mk(0, 1, 32'h10,       1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd0, 32'd0);
    vecs[25] = mk(0, 0, 32'h10,       0, 32'h4444_0010, 1, 0, 32'h0,       1, 32'h10, 32'd0, 32'd1);
    vecs[26] = mk(0, 1, 32'h10,       1, 32'h0,        1, 1, 32'h4444_0010, 0, 32'h0, 32'd0, 32'd1);
    // Reset also invalidated 0x0; then byte-offset bits are ignored on lookup
    vecs[27] = mk(0, 1, 32'h0,        1, 32'h0,        1, 0, 32'h0,        0, 32'h0,  32'd1, 32'd1);
    vecs[28] = mk(0, 0, 32'h0,        0, 32'h2001_0004, 1, 0, 32'h0,       1, 32'h0,  32'd1, 32'd2);
    vecs[29] = mk(0, 1, 32'h3,        1, 32'h0,        1, 1, 32'h2001_0004, 0, 32'h0, 32'd1, 32'd2);

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      RST = vecs[i].rst; imemREN = vecs[i].ren; imemaddr = vecs[i].addr;
      iwait = vecs[i].iwait; iload = vecs[i].iload;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d ihit", i),       {31'h0, ihit},  {31'h0, vecs[i].e_hit});
        check($sformatf("v%0d imemload", i),   imemload,       vecs[i].e_load);
        check($sformatf("v%0d iREN", i),       {31'h0, iREN},  {31'h0, vecs[i].e_iren});
        check($sformatf("v%0d iaddr", i),      iaddr,          vecs[i].e_iaddr);
        check($sformatf("v%0d hit_count", i),  hit_count,      vecs[i].e_hits);
        check($sformatf("v%0d miss_count", i), miss_count,     vecs[i].e_misses);
      end
    end

    // Hit-counter saturation: preload near the top, then keep hitting 0x0.
    @(negedge CLK);
    dut.hit_q = 32'hFFFF_FFFE;
    RST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
    #1;
    check("sat preload ihit", {31'h0, ihit}, 32'd1);
    check("sat preload count", hit_count, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1;
      check($sformatf("sat hit%0d ihit", k), {31'h0, ihit}, 32'd1);
      check($sformatf("sat hit%0d count", k), hit_count, 32'hFFFF_FFFF);
    end
    check("sat miss_count untouched", miss_count, 32'd2);

    imemREN = 1'b0;
    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
